// File: rtl/maf_round_pack.sv
// Round/pack stage of the MAF datapath: RNE rounding, carry renormalisation,
// exponent range checks and IEEE packing for one single or two half lanes.
module maf_round_pack #(
  parameter int EXP_W = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              cont,
  input  logic [23:0]             m_in,
  input  logic [1:0]              grd,
  input  logic [1:0]              stk,
  input  logic signed [EXP_W-1:0] exp0,
  input  logic signed [EXP_W-1:0] exp1,
  input  logic [1:0]              sgn,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             result,
  output logic [1:0]              flag_ovf,
  output logic [1:0]              flag_unf,
  output logic [1:0]              flag_inx
);

  typedef enum logic [1:0] {MODE_SGL, MODE_HALF, MODE_BAD} mode_t;

  localparam logic signed [EXP_W:0] SMAX  = (EXP_W+1)'(255);
  localparam logic signed [EXP_W:0] HMAX  = (EXP_W+1)'(31);
  localparam logic signed [EXP_W:0] EZERO = '0;

  mode_t                   w_mode, r_mode;
  logic                    w_adv;
  logic [1:0]              w_inc;
  logic                    r_v1, r_ovalid;
  logic [23:0]             r_m;
  logic [1:0]              r_grd, r_stk, r_sgn, r_inc;
  logic signed [EXP_W-1:0] r_exp0, r_exp1;
  logic [31:0]             r_result, w_result;
  logic [1:0]              r_ovf, r_unf, r_inx, w_ovf, w_unf, w_inx;

  assign w_adv     = !r_ovalid || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_ovalid;
  assign result    = r_result;
  assign flag_ovf  = r_ovf;
  assign flag_unf  = r_unf;
  assign flag_inx  = r_inx;

  always_comb begin
    case (cont)
      3'b000, 3'b010: w_mode = MODE_SGL;
      3'b001:         w_mode = MODE_HALF;
      default:        w_mode = MODE_BAD;
    endcase
  end

  // Lane0 LSB is m_in[0] in both modes; lane1 LSB sits at m_in[12].
  assign w_inc = {grd[1] & (stk[1] | m_in[12]), grd[0] & (stk[0] | m_in[0])};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v1   <= 1'b0;
      r_mode <= MODE_BAD;
      r_m    <= '0;
      r_grd  <= '0;
      r_stk  <= '0;
      r_sgn  <= '0;
      r_inc  <= '0;
      r_exp0 <= '0;
      r_exp1 <= '0;
    end else if (w_adv) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_mode <= w_mode;
        r_m    <= m_in;
        r_grd  <= grd;
        r_stk  <= stk;
        r_sgn  <= sgn;
        r_inc  <= w_inc;
        r_exp0 <= exp0;
        r_exp1 <= exp1;
      end
    end
  end

  // Returns {ovf, unf, inx, sign, exp[4:0], frac[9:0]} for one half lane.
  function automatic logic [18:0] pack_half(input logic s, input logic [10:0] m,
                                            input logic g, input logic k, input logic inc,
                                            input logic signed [EXP_W-1:0] e);
    logic [11:0]             sum;
    logic [10:0]             mr;
    logic signed [EXP_W:0]   ea;
    logic [18:0]             r;
    sum = {1'b0, m} + {11'd0, inc};
    mr  = sum[11] ? 11'h400 : sum[10:0];
    ea  = $signed({e[EXP_W-1], e}) + $signed({{EXP_W{1'b0}}, sum[11]});
    r   = '0;
    if (m == 11'd0 && !g && !k)
      r[15] = s;
    else if (ea >= HMAX)
      r = {3'b101, s, 5'h1F, 10'h000};
    else if (ea <= EZERO)
      r = {2'b01, (|m) | g | k, s, 15'h0000};
    else
      r = {2'b00, g | k, s, ea[4:0], mr[9:0]};
    return r;
  endfunction

  logic [24:0]           w_sum_s;
  logic [23:0]           w_mnt_s;
  logic signed [EXP_W:0] w_e_s;
  logic [18:0]           w_h0, w_h1;

  always_comb begin
    w_sum_s  = {1'b0, r_m} + {24'd0, r_inc[0]};
    w_mnt_s  = w_sum_s[24] ? 24'h800000 : w_sum_s[23:0];
    w_e_s    = $signed({r_exp0[EXP_W-1], r_exp0}) + $signed({{EXP_W{1'b0}}, w_sum_s[24]});
    w_h0     = pack_half(r_sgn[0], r_m[10:0], r_grd[0], r_stk[0], r_inc[0], r_exp0);
    w_h1     = pack_half(r_sgn[1], r_m[22:12], r_grd[1], r_stk[1], r_inc[1], r_exp1);
    w_result = '0;
    w_ovf    = '0;
    w_unf    = '0;
    w_inx    = '0;
    case (r_mode)
      MODE_SGL: begin
        if (r_m == 24'd0 && !r_grd[0] && !r_stk[0]) begin
          w_result = {r_sgn[0], 31'd0};
        end else if (w_e_s >= SMAX) begin
          w_result = {r_sgn[0], 8'hFF, 23'd0};
          w_ovf[0] = 1'b1;
          w_inx[0] = 1'b1;
        end else if (w_e_s <= EZERO) begin
          w_result = {r_sgn[0], 31'd0};
          w_unf[0] = 1'b1;
          w_inx[0] = (|r_m) | r_grd[0] | r_stk[0];
        end else begin
          w_result = {r_sgn[0], w_e_s[7:0], w_mnt_s[22:0]};
          w_inx[0] = r_grd[0] | r_stk[0];
        end
      end
      MODE_HALF: begin
        w_result = {w_h1[15:0], w_h0[15:0]};
        w_ovf    = {w_h1[18], w_h0[18]};
        w_unf    = {w_h1[17], w_h0[17]};
        w_inx    = {w_h1[16], w_h0[16]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovalid <= 1'b0;
      r_result <= '0;
      r_ovf    <= '0;
      r_unf    <= '0;
      r_inx    <= '0;
    end else if (w_adv) begin
      r_ovalid <= r_v1;
      if (r_v1) begin
        r_result <= w_result;
        r_ovf    <= w_ovf;
        r_unf    <= w_unf;
        r_inx    <= w_inx;
      end
    end
  end

endmodule
